// File: rtl/bram_readout_fsm_pkg.sv
// Shared types for the capture-BRAM readout engine: state encoding and default geometry.
package bram_readout_fsm_pkg;

   localparam int DEF_NB_ADDR = 11;
   localparam int DEF_NB_DATA = 14;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SEND  = 3'd3,
      ST_DONE  = 3'd4
   } rd_state_e;

   function automatic logic state_is_busy(input rd_state_e st);
      return (st == ST_FETCH) || (st == ST_WAIT) || (st == ST_SEND);
   endfunction

endpackage

// File: rtl/bram_readout_fsm.sv
// Walks the capture BRAM from address 0 to N_WORDS-1 after a start pulse and streams each
// word to a consumer over valid/ready; one word per three cycles when never back-pressured.
//
// state | meaning
// IDLE  | waiting for start with memory full; o_done holds the last completion
// FETCH | read enable asserted for the current address
// WAIT  | BRAM read latency; data captured at the end of this cycle
// SEND  | o_valid high, word held until accepted
// DONE  | one-cycle completion marker before returning to IDLE
module bram_readout_fsm
   import bram_readout_fsm_pkg::*;
#(
   parameter int NB_ADDR = DEF_NB_ADDR,
   parameter int NB_DATA = DEF_NB_DATA,
   parameter int N_WORDS = 2 ** NB_ADDR
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_mem_full,
   output logic [NB_ADDR-1:0] o_read_addr,
   output logic               o_read_enable,
   input  logic [NB_DATA-1:0] i_read_data,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_busy,
   output logic               o_done
);

   // Compared explicitly so dumps shorter than the address space stop on time.
   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

   rd_state_e          state_q, state_d;
   logic [NB_ADDR-1:0] addr_q, addr_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = done_q;

      if (i_stop && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_start && i_mem_full) begin
                  state_d = ST_FETCH;
                  addr_d  = '0;
                  done_d  = 1'b0;
               end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
               data_d  = i_read_data;
               valid_d = 1'b1;
               state_d = ST_SEND;
            end
            ST_SEND: begin
               if (valid_q && i_ready) begin
                  valid_d = 1'b0;
                  if (addr_q == LAST_ADDR) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     addr_d  = addr_q + NB_ADDR'(1);
                     state_d = ST_FETCH;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign o_read_addr   = addr_q;
   assign o_read_enable = (state_q == ST_FETCH);
   assign o_data        = data_q;
   assign o_valid       = valid_q;
   assign o_busy        = state_is_busy(state_q);
   assign o_done        = done_q;

endmodule

// File: tb/tb_bram_readout_fsm.sv
// Directed and randomized checks of the BRAM readout engine against a word-list/timing model.
module tb_bram_readout_fsm;

   localparam int NB_ADDR = 4;
   localparam int NB_DATA = 14;
   localparam int N_WORDS = 8;

   logic               clock = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_start = 1'b0;
   logic               i_stop = 1'b0;
   logic               i_mem_full = 1'b0;
   logic [NB_ADDR-1:0] o_read_addr;
   logic               o_read_enable;
   logic [NB_DATA-1:0] i_read_data = '0;
   logic [NB_DATA-1:0] o_data;
   logic               o_valid;
   logic               i_ready = 1'b1;
   logic               o_busy;
   logic               o_done;

   logic [NB_DATA-1:0] mem [0:(2**NB_ADDR)-1];

   int total = 0;
   int bad = 0;

   bram_readout_fsm #(
      .NB_ADDR(NB_ADDR),
      .NB_DATA(NB_DATA),
      .N_WORDS(N_WORDS)
   ) dut (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .i_mem_full   (i_mem_full),
      .o_read_addr  (o_read_addr),
      .o_read_enable(o_read_enable),
      .i_read_data  (i_read_data),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clock = ~clock;

   // Registered BRAM read port: data appears one cycle after enable.
   always @(posedge clock) begin
      if (o_read_enable) i_read_data <= mem[o_read_addr];
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one dump from a start pulse. Expected words come from mem[0..N_WORDS-1]; expected
   // duration is 3 cycles per word plus every cycle a valid word sat unaccepted.
   task automatic dump(input string name, input int stall_word, input int stop_word,
                       input int restart_word, input bit rnd, input bit drop_full);
      int  cycles, n_xfer, n_en, stalls;
      bit  stalled, restarted, aborted;
      cycles = 0; n_xfer = 0; n_en = 0; stalls = 0;
      stalled = 0; restarted = 0; aborted = 0;
      i_ready = 1'b1;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      if (drop_full) i_mem_full = 1'b0;
      check({name, "_start_clears_done"}, 32'(o_done), 32'd0);
      while (cycles < 400) begin
         if (o_done) break;
         check({name, "_busy"}, 32'(o_busy), 32'd1);
         n_en += int'(o_read_enable);
         if (o_valid) begin
            check({name, "_data"}, 32'(o_data), 32'(mem[n_xfer]));
            check({name, "_addr"}, 32'(o_read_addr), 32'(n_xfer));
            if (n_xfer == stop_word) begin
               i_stop = 1'b1;
               i_ready = 1'b1;
               step();
               i_stop = 1'b0;
               aborted = 1;
               break;
            end
            if (n_xfer == restart_word && !restarted) begin
               i_start = 1'b1;
               restarted = 1;
            end
            if (n_xfer == stall_word && !stalled) begin
               stalled = 1;
               i_ready = 1'b0;
               for (int s = 0; s < 5; s++) begin
                  step();
                  i_start = 1'b0;
                  cycles++;
                  stalls++;
                  check({name, "_stall_valid"}, 32'(o_valid), 32'd1);
                  check({name, "_stall_data"}, 32'(o_data), 32'(mem[n_xfer]));
                  check({name, "_stall_addr"}, 32'(o_read_addr), 32'(n_xfer));
               end
               i_ready = 1'b1;
            end else begin
               i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (i_ready) n_xfer++;
            else stalls++;
         end else begin
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         step();
         i_start = 1'b0;
         cycles++;
      end
      i_ready = 1'b1;
      i_mem_full = 1'b1;
      if (aborted) begin
         check({name, "_abort_valid"}, 32'(o_valid), 32'd0);
         check({name, "_abort_busy"}, 32'(o_busy), 32'd0);
         check({name, "_abort_done"}, 32'(o_done), 32'd0);
         check({name, "_abort_addr"}, 32'(o_read_addr), 32'd0);
         check({name, "_abort_en"}, 32'(o_read_enable), 32'd0);
         check({name, "_abort_words"}, 32'(n_xfer), 32'(stop_word));
         step();
         check({name, "_abort_idle"}, 32'(o_busy), 32'd0);
      end else begin
         check({name, "_done"}, 32'(o_done), 32'd1);
         check({name, "_words"}, 32'(n_xfer), 32'(N_WORDS));
         check({name, "_enables"}, 32'(n_en), 32'(N_WORDS));
         check({name, "_cycles"}, 32'(cycles), 32'(3 * N_WORDS + stalls));
         check({name, "_done_not_busy"}, 32'(o_busy), 32'd0);
         step();
         check({name, "_done_held"}, 32'(o_done), 32'd1);
         check({name, "_idle_after_done"}, 32'(o_busy), 32'd0);
      end
   endtask

   initial begin
      for (int k = 0; k < 2 ** NB_ADDR; k++) mem[k] = NB_DATA'(14'h100 + k);

      // Power-on reset.
      repeat (3) step();
      check("rst_addr", 32'(o_read_addr), 32'd0);
      check("rst_en", 32'(o_read_enable), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      i_reset = 1'b0;
      step();

      // Start without a full memory is ignored.
      i_mem_full = 1'b0;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check("gate_en", 32'(o_read_enable), 32'd0);
         check("gate_busy", 32'(o_busy), 32'd0);
         step();
      end

      // Full dump with ready tied high.
      i_mem_full = 1'b1;
      dump("full", -1, -1, -1, 1'b0, 1'b0);

      // Done survives an ignored start.
      i_mem_full = 1'b0;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      check("gate_keeps_done", 32'(o_done), 32'd1);
      check("gate_keeps_idle", 32'(o_busy), 32'd0);
      i_mem_full = 1'b1;

      dump("bp", 3, -1, -1, 1'b0, 1'b0);
      dump("abort", -1, 4, -1, 1'b0, 1'b0);
      dump("replay", -1, -1, -1, 1'b0, 1'b0);
      dump("restart", -1, -1, 2, 1'b0, 1'b0);

      // Reset held three cycles in the middle of SEND.
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 0; c < 10 && !o_valid; c++) step();
      check("pre_rst_valid", 32'(o_valid), 32'd1);
      i_reset = 1'b1;
      repeat (3) step();
      check("mid_rst_addr", 32'(o_read_addr), 32'd0);
      check("mid_rst_en", 32'(o_read_enable), 32'd0);
      check("mid_rst_data", 32'(o_data), 32'd0);
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      check("mid_rst_done", 32'(o_done), 32'd0);
      i_reset = 1'b0;
      step();
      check("post_rst_idle", 32'(o_busy), 32'd0);
      check("post_rst_valid", 32'(o_valid), 32'd0);

      // Random contents and random consumer readiness; mem_full dropped mid-dump in one pass.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 2 ** NB_ADDR; k++) mem[k] = NB_DATA'($urandom);
         dump("rand", -1, -1, -1, 1'b1, r[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
